// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 hex keypad scanner.
// KEYMAP is indexed [row][column], column 0 being the col[0] strobe.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2
  } state_t;

  localparam logic [3:0] KEYMAP [4][4] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'h0, 4'hF, 4'hE, 4'hD}
  };

  // Position of the single low bit in an active-low one-cold column strobe.
  function automatic logic [1:0] col_index(input logic [3:0] col);
    logic [1:0] idx;
    case (col)
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/keypad_row_sync.sv
// Two-flop synchronizer for the asynchronous, active-low row lines.
// Resets to all ones so the scanner sees "no key" right after reset.
module keypad_row_sync (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] d,
  output logic [3:0] q
);

  logic [3:0] meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 4'hF;
      q    <= 4'hF;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scan.sv
// Column-strobing scanner and debouncer for a 4x4 hex keypad; reports each
// accepted key once via key_valid and tracks it with key_held until release.
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int N   = 16,
  parameter int DEB = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key,
  output logic       key_valid,
  output logic       key_held,
  output logic [1:0] dbg_state
);

  localparam int DW = $clog2(DEB + 1);
  localparam logic [DW-1:0] DEB_MAX = DW'(DEB);

  logic [3:0]    row_s;
  logic [N-1:0]  dwell;
  logic          sample;
  state_t        state, state_d;
  logic [3:0]    col_d, col_rot, key_d;
  logic          valid_d, held_d;
  logic [DW-1:0] deb_cnt, deb_d, rel_cnt, rel_d;
  logic [1:0]    lat_row, lat_row_d, win_row;

  keypad_row_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (row),
    .q     (row_s)
  );

  assign sample    = &dwell;
  assign col_rot   = {col[2:0], col[3]};
  assign dbg_state = state;

  // Lowest-index low row wins when several rows are pulled down together.
  always_comb begin
    win_row = 2'd3;
    for (int r = 3; r >= 0; r--) begin
      if (!row_s[r]) win_row = 2'(r);
    end
  end

  always_comb begin
    state_d   = state;
    col_d     = col;
    key_d     = key;
    valid_d   = 1'b0;
    held_d    = key_held;
    deb_d     = deb_cnt;
    rel_d     = rel_cnt;
    lat_row_d = lat_row;
    if (sample) begin
      case (state)
        SCAN: begin
          if (row_s == 4'hF) begin
            col_d = col_rot;
          end else begin
            lat_row_d = win_row;
            deb_d     = '0;
            state_d   = DEBOUNCE;
          end
        end
        DEBOUNCE: begin
          if (!row_s[lat_row]) begin
            deb_d = (deb_cnt == DEB_MAX) ? deb_cnt : deb_cnt + 1'b1;
            if (deb_d == DEB_MAX) begin
              key_d   = KEYMAP[lat_row][col_index(col)];
              valid_d = 1'b1;
              held_d  = 1'b1;
              rel_d   = '0;
              state_d = HELD;
            end
          end else begin
            col_d   = col_rot;
            state_d = SCAN;
          end
        end
        HELD: begin
          // Only the latched row matters; the frozen column hides other keys.
          if (row_s[lat_row]) begin
            rel_d = (rel_cnt == DEB_MAX) ? rel_cnt : rel_cnt + 1'b1;
            if (rel_d == DEB_MAX) begin
              held_d  = 1'b0;
              col_d   = col_rot;
              state_d = SCAN;
            end
          end else begin
            rel_d = '0;
          end
        end
        default: state_d = SCAN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dwell     <= '0;
      state     <= SCAN;
      col       <= 4'b1110;
      key       <= 4'h0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
      deb_cnt   <= '0;
      rel_cnt   <= '0;
      lat_row   <= 2'd0;
    end else begin
      dwell     <= dwell + 1'b1;
      state     <= state_d;
      col       <= col_d;
      key       <= key_d;
      key_valid <= valid_d;
      key_held  <= held_d;
      deb_cnt   <= deb_d;
      rel_cnt   <= rel_d;
      lat_row   <= lat_row_d;
    end
  end

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan with a 4-cycle dwell (N=2) and DEB=3.
// The keypad model pulls row r low while key (r,c) is pressed and col[c] is low.
module tb_keypad_scan;
  import keypad_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key;
  logic       key_valid;
  logic       key_held;
  logic [1:0] dbg_state;

  logic [3:0] pressed [4];
  int tests = 0;
  int failed = 0;
  int pulses = 0;

  keypad_scan #(.N(2), .DEB(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .row       (row),
    .col       (col),
    .key       (key),
    .key_valid (key_valid),
    .key_held  (key_held),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (pressed[r][c] && !col[c]) row[r] = 1'b0;
      end
    end
  end

  // Advance n clocks, sampling 1 time unit after each edge and counting pulses.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (key_valid === 1'b1) pulses++;
    end
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_keys();
    for (int r = 0; r < 4; r++) pressed[r] = 4'h0;
  endtask

  initial begin
    clear_keys();
    step(3);
    check("rst_col", col, 8'hE);
    check("rst_key", key, 8'h0);
    check("rst_valid", key_valid, 8'h0);
    check("rst_held", key_held, 8'h0);
    check("rst_state", dbg_state, SCAN);
    reset = 1'b0;

    // Idle rotation: each column is held for 4 cycles.
    step(3);
    check("idle_col0_hold", col, 8'hE);
    step(1);
    check("idle_col1", col, 8'hD);
    step(4);
    check("idle_col2", col, 8'hB);
    step(4);
    check("idle_col3", col, 8'h7);
    step(4);
    check("idle_wrap", col, 8'hE);
    check("idle_pulses", pulses, 8'd0);

    // Key 5 (r1,c1): detected at edge 8, confirmed at 12/16/20.
    pressed[1][1] = 1'b1;
    step(19);
    check("k5_col_frozen", col, 8'hD);
    check("k5_early_valid", key_valid, 8'h0);
    check("k5_state_deb", dbg_state, DEBOUNCE);
    step(1);
    check("k5_valid", key_valid, 8'h1);
    check("k5_key", key, 8'h5);
    check("k5_held", key_held, 8'h1);
    step(1);
    check("k5_valid_one_cycle", key_valid, 8'h0);
    check("k5_still_held", key_held, 8'h1);
    clear_keys();
    step(10);
    check("k5_held_before_release", key_held, 8'h1);
    step(1);
    check("k5_released", key_held, 8'h0);
    check("k5_col_advance", col, 8'hB);
    check("k5_pulses", pulses, 8'd1);

    // Key E (r3,c2) seen at only two sample points: must be rejected.
    pressed[3][2] = 1'b1;
    step(8);
    check("kE_col_frozen", col, 8'hB);
    check("kE_state_deb", dbg_state, DEBOUNCE);
    clear_keys();
    step(4);
    check("kE_col_resume", col, 8'h7);
    check("kE_key_unchanged", key, 8'h5);
    check("kE_state_scan", dbg_state, SCAN);
    check("kE_pulses", pulses, 8'd1);

    // Key A (r0,c3) accepted; '1' pressed meanwhile; release with one bounce.
    pressed[0][3] = 1'b1;
    step(16);
    check("kA_valid", key_valid, 8'h1);
    check("kA_key", key, 8'hA);
    check("kA_held", key_held, 8'h1);
    pressed[0][0] = 1'b1;
    pressed[0][3] = 1'b0;
    step(4);
    pressed[0][3] = 1'b1;
    step(4);
    pressed[0][3] = 1'b0;
    step(11);
    check("kA_bounce_held", key_held, 8'h1);
    check("kA_bounce_col", col, 8'h7);
    check("kA_bounce_key", key, 8'hA);
    check("kA_pulses", pulses, 8'd2);
    step(1);
    check("kA_released", key_held, 8'h0);
    check("kA_col_advance", col, 8'hE);
    step(16);
    check("k1_valid", key_valid, 8'h1);
    check("k1_key", key, 8'h1);
    check("k1_pulses", pulses, 8'd3);
    pressed[0][0] = 1'b0;
    step(11);
    check("k1_held_before_release", key_held, 8'h1);
    step(1);
    check("k1_released", key_held, 8'h0);
    check("k1_col_advance", col, 8'hD);

    // Keys 4 (r1,c0) and 0 (r3,c0) together: lowest row wins.
    pressed[1][0] = 1'b1;
    pressed[3][0] = 1'b1;
    step(27);
    check("k40_no_early", key_valid, 8'h0);
    check("k40_col", col, 8'hE);
    step(1);
    check("k40_valid", key_valid, 8'h1);
    check("k40_key", key, 8'h4);

    // One-cycle reset while HELD.
    step(2);
    check("rst2_pre_held", key_held, 8'h1);
    check("rst2_pre_state", dbg_state, HELD);
    reset = 1'b1;
    step(1);
    check("rst2_col", col, 8'hE);
    check("rst2_key", key, 8'h0);
    check("rst2_held", key_held, 8'h0);
    check("rst2_valid", key_valid, 8'h0);
    check("rst2_state", dbg_state, SCAN);
    clear_keys();
    reset = 1'b0;
    step(8);
    check("rst2_col_resume", col, 8'hB);
    check("rst2_no_spurious", pulses, 8'd4);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
